// File: rtl/latch_bank_pkg.sv
// latch_bank shared types and helpers.
// Build option: LATCH_BANK_TRANSPARENT_EN (combinational q while gate open).
package latch_bank_pkg;

    typedef enum logic {
        CLOSED = 1'b0,
        OPEN   = 1'b1
    } gate_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/latch_bank_if.sv
// latch_bank data, gate and history-read bundle.
// Width parameters must match the latch_bank instance.
interface latch_bank_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4
);
    import latch_bank_pkg::*;

    localparam int CHW  = clog2_min1(CHANNELS);
    localparam int SELW = clog2_min1(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [CHANNELS*WIDTH-1:0] d;
    logic [CHANNELS-1:0]       c;
    logic [CHANNELS*WIDTH-1:0] q;
    logic [CHANNELS-1:0]       closed;
    logic [CHW-1:0]            hist_ch;
    logic [SELW-1:0]           hist_sel;
    logic [WIDTH-1:0]          hist_q;
    logic [CNTW-1:0]           hist_cnt;

    modport master (
        output d, c, hist_ch, hist_sel,
        input  q, closed, hist_q, hist_cnt
    );

    modport slave (
        input  d, c, hist_ch, hist_sel,
        output q, closed, hist_q, hist_cnt
    );

endinterface

// File: rtl/latch_bank_chan.sv
// One latch channel: held value, gate FSM, close history and count.
// LATCH_BANK_TRANSPARENT_EN makes q follow d while the gate is open.
module latch_bank_chan
    import latch_bank_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH-1:0]            d,
    input  logic                        c,
    output logic [WIDTH-1:0]            q,
    output logic                        closed,
    output logic [DEPTH-1:0][WIDTH-1:0] hist,
    output logic [CNTW-1:0]             cnt
);

    gate_state_e      state;
    gate_state_e      state_nxt;
    logic             load;
    logic             close_evt;
    logic [WIDTH-1:0] held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CLOSED;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        close_evt = 1'b0;
        unique case (state)
            CLOSED: begin
                if (c) begin
                    state_nxt = OPEN;
                    load      = 1'b1;
                end
            end
            OPEN: begin
                if (c) begin
                    load = 1'b1;
                end else begin
                    state_nxt = CLOSED;
                    close_evt = 1'b1;
                end
            end
        endcase
    end

    // held is the last value loaded while open, so it is what a close logs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held   <= '0;
            closed <= 1'b0;
            hist   <= '0;
            cnt    <= '0;
        end else begin
            closed <= close_evt;
            if (load) held <= d;
            if (close_evt) begin
                hist <= {hist[DEPTH-2:0], held};
                if (cnt != CNTW'(DEPTH)) cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef LATCH_BANK_TRANSPARENT_EN
    assign q = c ? d : held;
`else
    assign q = held;
`endif

endmodule

// File: rtl/latch_bank.sv
// Multi-channel gated latch bank with per-channel close history.
// Build option: LATCH_BANK_TRANSPARENT_EN (zero-latency q while open).
module latch_bank
    import latch_bank_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4
) (
    input logic         clk,
    input logic         rst_n,
    latch_bank_if.slave bus
);

    localparam int CNTW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] hist_a [CHANNELS];
    logic [CNTW-1:0]             cnt_a  [CHANNELS];
    logic [CHANNELS*WIDTH-1:0]   q_v;
    logic [CHANNELS-1:0]         closed_v;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        latch_bank_chan #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .CNTW  (CNTW)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .d      (bus.d[k*WIDTH +: WIDTH]),
            .c      (bus.c[k]),
            .q      (q_v[k*WIDTH +: WIDTH]),
            .closed (closed_v[k]),
            .hist   (hist_a[k]),
            .cnt    (cnt_a[k])
        );
    end

    assign bus.q      = q_v;
    assign bus.closed = closed_v;

    // entries at or beyond the count were never logged and read as 0
    always_comb begin
        bus.hist_q   = '0;
        bus.hist_cnt = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(bus.hist_ch) == k) begin
                bus.hist_cnt = cnt_a[k];
                for (int i = 0; i < DEPTH; i++) begin
                    if (int'(bus.hist_sel) == i && i < int'(cnt_a[k]))
                        bus.hist_q = hist_a[k][i];
                end
            end
        end
    end

endmodule

// File: tb/tb_latch_bank.sv
// Self-checking bench for latch_bank against a queue-based reference model.
// Honours LATCH_BANK_TRANSPARENT_EN for the expected q.
module tb_latch_bank;

    localparam int W  = 4;
    localparam int CH = 2;
    localparam int DP = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    latch_bank_if #(.WIDTH(W), .CHANNELS(CH), .DEPTH(DP)) bus ();

    latch_bank #(.WIDTH(W), .CHANNELS(CH), .DEPTH(DP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #20 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0]  m_held [CH];
    logic          m_open [CH];
    logic [CH-1:0] m_closed;
    logic [W-1:0]  m_hist [CH][$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CH*W-1:0] exp_q();
        logic [CH*W-1:0] v;
        for (int k = 0; k < CH; k++) begin
`ifdef LATCH_BANK_TRANSPARENT_EN
            v[k*W +: W] = bus.c[k] ? bus.d[k*W +: W] : m_held[k];
`else
            v[k*W +: W] = m_held[k];
`endif
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            m_held[k] = '0;
            m_open[k] = 1'b0;
            m_hist[k].delete();
        end
        m_closed = '0;
    endtask

    task automatic model_edge();
        for (int k = 0; k < CH; k++) begin
            m_closed[k] = m_open[k] && !bus.c[k];
            if (m_closed[k]) begin
                m_hist[k].push_front(m_held[k]);
                if (m_hist[k].size() > DP) void'(m_hist[k].pop_back());
            end
            if (bus.c[k]) m_held[k] = bus.d[k*W +: W];
            m_open[k] = bus.c[k];
        end
    endtask

    task automatic scan();
        logic [W-1:0] e;
        for (int ch = 0; ch < CH; ch++) begin
            for (int s = 0; s < DP; s++) begin
                bus.hist_ch  = 1'(ch);
                bus.hist_sel = 2'(s);
                #1;
                e = (s < m_hist[ch].size()) ? m_hist[ch][s] : '0;
                chk($sformatf("hist_q_c%0d_s%0d", ch, s), 32'(bus.hist_q), 32'(e));
                chk($sformatf("hist_cnt_c%0d", ch), 32'(bus.hist_cnt),
                    32'(m_hist[ch].size()));
            end
        end
    endtask

    task automatic hist_rd(input int ch, input int s, output logic [W-1:0] v);
        bus.hist_ch  = 1'(ch);
        bus.hist_sel = 2'(s);
        #1;
        v = bus.hist_q;
    endtask

    task automatic edge_chk();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        chk("q", 32'(bus.q), 32'(exp_q()));
        chk("closed", 32'(bus.closed), 32'(m_closed));
        scan();
    endtask

    task automatic step(input logic [CH-1:0] cv, input logic [CH*W-1:0] dv);
        @(negedge clk);
        bus.c = cv;
        bus.d = dv;
        #1;
        chk("q_mid", 32'(bus.q), 32'(exp_q()));
        edge_chk();
    endtask

    logic [W-1:0] hv;

    initial begin
        bus.c        = 2'b11;
        bus.d        = 8'hFF;
        bus.hist_ch  = '0;
        bus.hist_sel = '0;
        model_reset();

        #5;
        chk("rst_q", 32'(bus.q), 32'(exp_q()));
        chk("rst_closed", 32'(bus.closed), 32'h0);
        chk("rst_hist_cnt", 32'(bus.hist_cnt), 32'h0);
        chk("rst_hist_q", 32'(bus.hist_q), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        edge_chk();
        chk("release_q", 32'(bus.q), 32'hFF);

        step(2'b01, 8'h0F);
        step(2'b01, 8'h0F);
        step(2'b01, 8'h0C);
        step(2'b00, 8'h0C);
        chk("close_pulse", 32'(bus.closed), 32'h1);
        hist_rd(0, 0, hv);
        chk("close_hist0", 32'(hv), 32'hC);
        chk("close_cnt0", 32'(bus.hist_cnt), 32'h1);
        step(2'b00, 8'h35);
        chk("hold_q0", 32'(bus.q[3:0]), 32'hC);
        chk("pulse_once", 32'(bus.closed), 32'h0);

        for (int v = 1; v <= 6; v++) begin
            step(2'b10, 8'(v << 4));
            step(2'b00, 8'(v << 4));
        end
        for (int s = 0; s < DP; s++) begin
            hist_rd(1, s, hv);
            chk($sformatf("wrap_s%0d", s), 32'(hv), 32'(6 - s));
        end
        chk("wrap_cnt", 32'(bus.hist_cnt), 32'h4);

        step(2'b11, 8'h5A);
        step(2'b00, 8'h5A);
        chk("sim_closed", 32'(bus.closed), 32'h3);
        hist_rd(0, 0, hv);
        chk("sim_ch0", 32'(hv), 32'hA);
        hist_rd(1, 0, hv);
        chk("sim_ch1", 32'(hv), 32'h5);

        step(2'b01, 8'h09);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        bus.c = 2'b00;
        model_reset();
        #1;
        chk("midrst_q", 32'(bus.q), 32'h0);
        chk("midrst_closed", 32'(bus.closed), 32'h0);
        scan();
        @(negedge clk);
        rst_n = 1'b1;
        edge_chk();
        chk("norelog_closed", 32'(bus.closed), 32'h0);
        chk("norelog_cnt", 32'(bus.hist_cnt), 32'h0);

        for (int i = 0; i < 300; i++) begin
            step(2'($urandom), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
